// File: rtl/mac_pipe_acc.sv
// mac_pipe_acc: LANES-wide signed dot-product pipeline feeding a saturating or wrapping group accumulator.
// Three stages: lane products, adder tree, accumulate; an unaccepted result freezes the whole pipe.
module mac_pipe_acc #(
    parameter int LANES = 8,
    parameter int DW    = 8,
    parameter int ACCW  = 32,
    parameter bit SAT   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*DW-1:0]   data,
    input  logic [LANES*DW-1:0]   weight,
    input  logic                  first,
    input  logic                  last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACCW-1:0]       result,
    output logic                  ovf
);
    localparam int PW = 2 * DW;
    localparam int TW = PW + $clog2(LANES);

    logic                  w_stall;
    logic signed [PW-1:0]  w_prod [LANES];
    logic signed [PW-1:0]  r_prod [LANES];
    logic                  r_s1_v, r_s1_first, r_s1_last;
    logic signed [TW-1:0]  w_tree, r_s2_sum;
    logic                  r_s2_v, r_s2_first, r_s2_last;
    logic signed [ACCW:0]  w_sum;
    logic                  w_of, w_grp_ovf;
    logic signed [ACCW-1:0] r_acc, w_acc;
    logic                  r_ovf_acc;

    assign w_stall  = out_valid && !out_ready;
    assign in_ready = !w_stall;

    always_comb begin
        for (int i = 0; i < LANES; i++)
            w_prod[i] = PW'($signed(data[i*DW +: DW])) * PW'($signed(weight[i*DW +: DW]));
    end

    always_comb begin
        w_tree = '0;
        for (int i = 0; i < LANES; i++)
            w_tree = w_tree + TW'(r_prod[i]);
    end

    // Sum one bit wider than the accumulator so overflow shows as a sign-bit disagreement.
    always_comb begin
        w_sum     = (r_s2_first ? '0 : (ACCW+1)'(r_acc)) + (ACCW+1)'(r_s2_sum);
        w_of      = w_sum[ACCW] != w_sum[ACCW-1];
        w_acc     = (!w_of || !SAT) ? w_sum[ACCW-1:0] :
                    w_sum[ACCW] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
        w_grp_ovf = w_of || (!r_s2_first && r_ovf_acc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v    <= 1'b0;
            r_s2_v    <= 1'b0;
            r_acc     <= '0;
            r_ovf_acc <= 1'b0;
            result    <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else if (!w_stall) begin
            r_s1_v     <= in_valid;
            r_s1_first <= first;
            r_s1_last  <= last;
            r_prod     <= w_prod;
            r_s2_v     <= r_s1_v;
            r_s2_first <= r_s1_first;
            r_s2_last  <= r_s1_last;
            r_s2_sum   <= w_tree;
            out_valid  <= r_s2_v && r_s2_last;
            if (r_s2_v) begin
                r_acc     <= w_acc;
                r_ovf_acc <= w_grp_ovf;
                if (r_s2_last) begin
                    result <= w_acc;
                    ovf    <= w_grp_ovf;
                end
            end
        end
    end
endmodule
